des_comma_align: RTL

- Receive-side neighbour of the 8b/10b encode/serialize stage.
- Deserializes the serial 10b line stream, finds symbol boundaries from the 8b/10b comma sequence, and locks to them.
- Presents aligned 10-bit symbols, with valid and comma flags, to the downstream 10b/8b decoder.
- Bit order matches the transmitter: symbol bit 0 ('a') is on the wire first.

---
 rtl/des_comma_align.sv | 88 ++++++++
 1 files changed

// File: rtl/des_comma_align.sv
// des_comma_align: 10b deserializer that finds 8b/10b comma boundaries, locks to them
// and presents aligned symbols with valid/comma flags and a symbol-group index.
module des_comma_align #(
  parameter int ACQ_CNT  = 3,
  parameter int LOSS_CNT = 4
) (
  input  logic       bitclk,
  input  logic       rst_n,
  input  logic       sin,
  output logic [9:0] word_out,
  output logic       word_valid,
  output logic       word_comma,
  output logic [2:0] sym_idx,
  output logic       locked,
  output logic       align_err
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  localparam logic [3:0] ACQ  = 4'(ACQ_CNT);
  localparam logic [3:0] LOSS = 4'(LOSS_CNT);
  state_t     state;
  logic [9:0] sr;
  logic [3:0] ph, good_cnt, bad_cnt;
  logic       comma_hit, bnd;
  // abcdeif = 0011111 / 1100000 with bit a oldest in sr[0]
  assign comma_hit = sr[6:0] == 7'b1111100 || sr[6:0] == 7'b0000011;
  assign bnd = ph == 4'd9;
  always_ff @(posedge bitclk or negedge rst_n)
    if (!rst_n) begin
      state      <= HUNT;
      sr         <= '0;
      ph         <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      word_comma <= 1'b0;
      sym_idx    <= '0;
      locked     <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      sr         <= {sin, sr[9:1]};
      ph         <= bnd ? 4'd0 : ph + 4'd1;
      word_valid <= state == LOCKED && bnd;
      align_err  <= state == LOCKED && comma_hit && !bnd;
      if (state == LOCKED && bnd) begin
        word_out   <= sr;
        word_comma <= comma_hit;
        sym_idx    <= comma_hit ? 3'd0 : sym_idx + 3'd1;
      end
      case (state)
        HUNT:
          if (comma_hit) begin
            ph       <= 4'd0;
            good_cnt <= 4'd1;
            bad_cnt  <= 4'd0;
            state    <= (ACQ == 4'd1) ? LOCKED : VERIFY;
            locked   <= ACQ == 4'd1;
          end
        VERIFY:
          if (comma_hit && bnd) begin
            good_cnt <= good_cnt + 4'd1;
            if (good_cnt + 4'd1 == ACQ) begin
              state   <= LOCKED;
              locked  <= 1'b1;
              bad_cnt <= 4'd0;
            end
          end else if (comma_hit) begin
            ph       <= 4'd0;
            good_cnt <= 4'd1;
          end
        LOCKED:
          if (comma_hit && bnd)
            bad_cnt <= 4'd0;
          else if (comma_hit) begin
            bad_cnt <= bad_cnt + 4'd1;
            // lock is only dropped, never slipped; HUNT does the realignment
            if (bad_cnt + 4'd1 == LOSS) begin
              state    <= HUNT;
              locked   <= 1'b0;
              good_cnt <= 4'd0;
              bad_cnt  <= 4'd0;
              sym_idx  <= 3'd0;
            end
          end
        default: state <= HUNT;
      endcase
    end
endmodule
